// File: rtl/sram_word_responder.sv
// rtl/sram_word_responder.sv - single-word request responder for an asynchronous 32-bit SRAM
// One request in flight; nak holds off the initiator until the access sequence finishes.
module sram_word_responder #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stb,
    input  logic [31:0]       i_addr,
    input  logic [3:0]        i_dm,
    input  logic [31:0]       i_din,
    output logic [31:0]       o_dout,
    output logic              o_nak,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic [3:0]        o_sram_be_n,
    input  logic [31:0]       i_sram_dq,
    output logic [31:0]       o_sram_dq,
    output logic              o_sram_dq_t
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACC,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_nak, w_nak;
    logic [31:0]        r_dout, w_dout;
    logic [ADDR_W-1:0]  r_sram_addr, w_sram_addr;
    logic               r_ce_n, w_ce_n;
    logic               r_oe_n, w_oe_n;
    logic               r_we_n, w_we_n;
    logic [3:0]         r_be_n, w_be_n;
    logic [31:0]        r_dq_o, w_dq_o;
    logic               r_dq_t, w_dq_t;

    // Byte-lane and out-of-range address bits are intentionally dropped.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_nak       = r_nak;
        w_dout      = r_dout;
        w_sram_addr = r_sram_addr;
        w_ce_n      = r_ce_n;
        w_oe_n      = r_oe_n;
        w_we_n      = r_we_n;
        w_be_n      = r_be_n;
        w_dq_o      = r_dq_o;
        w_dq_t      = r_dq_t;
        case (r_state)
            S_IDLE: begin
                if (i_stb) begin
                    w_nak       = 1'b1;
                    w_sram_addr = i_addr[ADDR_W+1:2];
                    w_ce_n      = 1'b0;
                    if (i_dm == 4'b0000) begin
                        w_state = S_RD_ACC;
                        w_oe_n  = 1'b0;
                        w_be_n  = 4'b0000;
                        w_cnt   = RD_LOAD;
                    end else begin
                        w_state = S_WR_SETUP;
                        w_dq_t  = 1'b0;
                        w_dq_o  = i_din;
                        w_be_n  = ~i_dm;
                        w_cnt   = WR_LOAD;
                    end
                end
            end
            S_RD_ACC: begin
                if (r_cnt == '0) begin
                    w_dout  = i_sram_dq;
                    w_nak   = 1'b0;
                    w_ce_n  = 1'b1;
                    w_oe_n  = 1'b1;
                    w_be_n  = 4'hF;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_WR_SETUP: begin
                w_we_n  = 1'b0;
                w_state = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                // Address, lanes and data stay frozen here so the pulse sees stable inputs.
                if (r_cnt == '0) begin
                    w_we_n  = 1'b1;
                    w_state = S_WR_HOLD;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_WR_HOLD: begin
                w_nak   = 1'b0;
                w_dq_t  = 1'b1;
                w_ce_n  = 1'b1;
                w_be_n  = 4'hF;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_nak       <= 1'b0;
            r_dout      <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= 4'hF;
            r_dq_o      <= '0;
            r_dq_t      <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_nak       <= w_nak;
            r_dout      <= w_dout;
            r_sram_addr <= w_sram_addr;
            r_ce_n      <= w_ce_n;
            r_oe_n      <= w_oe_n;
            r_we_n      <= w_we_n;
            r_be_n      <= w_be_n;
            r_dq_o      <= w_dq_o;
            r_dq_t      <= w_dq_t;
        end
    end

    assign o_dout      = r_dout;
    assign o_nak       = r_nak;
    assign o_sram_addr = r_sram_addr;
    assign o_sram_ce_n = r_ce_n;
    assign o_sram_oe_n = r_oe_n;
    assign o_sram_we_n = r_we_n;
    assign o_sram_be_n = r_be_n;
    assign o_sram_dq   = r_dq_o;
    assign o_sram_dq_t = r_dq_t;

endmodule
